// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the EX-stage controller and alu_multicycle.
// The controller drives the request side (master); the ALU answers (slave).
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);

  logic             valid_i;
  logic [3:0]       ctrl_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] hi_o;
  logic             zero_o;
  logic             overflow_o;

  modport master (
    output valid_i, ctrl_i, src1_i, src2_i,
    input  ready_o, valid_o, result_o, hi_o, zero_o, overflow_o
  );

  modport slave (
    input  valid_i, ctrl_i, src1_i, src2_i,
    output ready_o, valid_o, result_o, hi_o, zero_o, overflow_o
  );

endinterface

// File: rtl/alu_multicycle.sv
// Registered ALU for the EX stage of the multi-cycle CPU.
// Logic/compare/add ops finish in one cycle; MULU (shift-add) and DIVU
// (restoring division) iterate one bit per clock and share one set of
// working registers: r_acc is the product high half / partial remainder,
// r_shift is the multiplier+product low half / dividend+quotient, and
// r_opB holds the multiplicand or the divisor.
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  alu_multicycle_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_shift;
  logic             r_valid;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_hi;
  logic             r_zero;
  logic             r_ovf;

  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_aluResult;
  logic             w_aluOvf;
  logic [WIDTH:0]   w_mulSum;
  logic [WIDTH:0]   w_trial;
  logic             w_divGe;
  logic [WIDTH-1:0] w_stepAcc;
  logic [WIDTH-1:0] w_stepShift;
  logic             w_lastStep;

  assign w_sum      = bus.src1_i + bus.src2_i;
  assign w_diff     = bus.src1_i - bus.src2_i;
  assign w_lastStep = (r_count == CNT_W'(1));

  // Single-cycle result and signed-overflow flag for the op currently requested
  always_comb begin
    w_aluResult = '0;
    w_aluOvf    = 1'b0;
    case (bus.ctrl_i)
      OP_AND:  w_aluResult = bus.src1_i & bus.src2_i;
      OP_OR:   w_aluResult = bus.src1_i | bus.src2_i;
      OP_NOR:  w_aluResult = ~(bus.src1_i | bus.src2_i);
      OP_ADD: begin
        w_aluResult = w_sum;
        w_aluOvf    = (bus.src1_i[WIDTH-1] == bus.src2_i[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      OP_SUB: begin
        w_aluResult = w_diff;
        w_aluOvf    = (bus.src1_i[WIDTH-1] != bus.src2_i[WIDTH-1]) &&
                      (w_diff[WIDTH-1] != bus.src1_i[WIDTH-1]);
      end
      OP_SLT:  w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(bus.src1_i) < $signed(bus.src2_i))};
      OP_SLTU: w_aluResult = {{(WIDTH-1){1'b0}}, (bus.src1_i < bus.src2_i)};
      default: w_aluResult = '0;
    endcase
  end

  // One iteration step: shift-add for MUL, trial-subtract for DIV
  always_comb begin
    w_mulSum = {1'b0, r_acc} + (r_shift[0] ? {1'b0, r_opB} : '0);
    w_trial  = {r_acc, r_shift[WIDTH-1]};
    w_divGe  = (w_trial >= {1'b0, r_opB});
    if (r_state == MUL) begin
      w_stepAcc   = w_mulSum[WIDTH:1];
      w_stepShift = {w_mulSum[0], r_shift[WIDTH-1:1]};
    end else begin
      w_stepAcc   = w_divGe ? (w_trial[WIDTH-1:0] - r_opB) : w_trial[WIDTH-1:0];
      w_stepShift = {r_shift[WIDTH-2:0], w_divGe};
    end
  end

  // Next-state: leave IDLE only for MULU/DIVU, return after the last bit
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (bus.valid_i && (bus.ctrl_i == OP_MULU)) w_nextState = MUL;
        else if (bus.valid_i && (bus.ctrl_i == OP_DIVU)) w_nextState = DIV;
      end
      MUL, DIV: begin
        if (w_lastStep) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  // Operand latching, iteration registers and the held result outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_count  <= '0;
      r_opB    <= '0;
      r_acc    <= '0;
      r_shift  <= '0;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_hi     <= '0;
      r_zero   <= 1'b1;
      r_ovf    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.valid_i) begin
          if (bus.ctrl_i == OP_MULU) begin
            r_opB   <= bus.src1_i;
            r_shift <= bus.src2_i;
            r_acc   <= '0;
            r_count <= CNT_W'(WIDTH);
          end else if (bus.ctrl_i == OP_DIVU) begin
            r_opB   <= bus.src2_i;
            r_shift <= bus.src1_i;
            r_acc   <= '0;
            r_count <= CNT_W'(WIDTH);
          end else begin
            r_result <= w_aluResult;
            r_hi     <= '0;
            r_zero   <= (w_aluResult == '0);
            r_ovf    <= w_aluOvf;
            r_valid  <= 1'b1;
          end
        end
      end else begin
        r_acc   <= w_stepAcc;
        r_shift <= w_stepShift;
        r_count <= r_count - CNT_W'(1);
        if (w_lastStep) begin
          r_result <= w_stepShift;
          r_hi     <= w_stepAcc;
          r_zero   <= (w_stepShift == '0);
          r_ovf    <= 1'b0;
          r_valid  <= 1'b1;
        end
      end
    end
  end

  assign bus.ready_o    = (r_state == IDLE);
  assign bus.valid_o    = r_valid;
  assign bus.result_o   = r_result;
  assign bus.hi_o       = r_hi;
  assign bus.zero_o     = r_zero;
  assign bus.overflow_o = r_ovf;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: a 32-bit and an 8-bit instance driven with
// directed cases and random requests, checked against an arithmetic model.
module tb_alu_multicycle;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  logic [3:0]  b2bCtrl[$];
  logic [63:0] b2bA[$];
  logic [63:0] b2bB[$];

  alu_multicycle_if #(.WIDTH(32)) bus32();
  alu_multicycle_if #(.WIDTH(8))  bus8();

  alu_multicycle #(.WIDTH(32)) dut32 (.clk_i(clk), .rst_i(rst), .bus(bus32));
  alu_multicycle #(.WIDTH(8))  dut8  (.clk_i(clk), .rst_i(rst), .bus(bus8));

  // Free-running clock
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not hold
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Expected behaviour straight from the op definitions, using wide integers
  function automatic void refModel(input int w, input logic [3:0] ctrl, input logic [63:0] a,
                                   input logic [63:0] b, output logic [63:0] res,
                                   output logic [63:0] hi, output logic ovf);
    logic [63:0] mask;
    logic [63:0] prod;
    longint sa, sb, sr, maxS, minS;
    mask = (64'd1 << w) - 64'd1;
    maxS = (longint'(1) << (w - 1)) - 1;
    minS = -(longint'(1) << (w - 1));
    sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    res  = 64'd0;
    hi   = 64'd0;
    ovf  = 1'b0;
    case (ctrl)
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b1100: res = ~(a | b) & mask;
      4'b0010: begin res = (a + b) & mask; sr = sa + sb; ovf = (sr > maxS) || (sr < minS); end
      4'b0110: begin res = (a - b) & mask; sr = sa - sb; ovf = (sr > maxS) || (sr < minS); end
      4'b0111: res = (sa < sb) ? 64'd1 : 64'd0;
      4'b1111: res = (a < b) ? 64'd1 : 64'd0;
      4'b1000: begin prod = a * b; res = prod & mask; hi = (prod >> w) & mask; end
      4'b1001: begin
        if (b == 64'd0) begin res = mask; hi = a; end
        else begin res = a / b; hi = a % b; end
      end
      default: res = 64'd0;
    endcase
  endfunction

  task automatic driveReq(input int w, input logic v, input logic [3:0] ctrl,
                          input logic [63:0] a, input logic [63:0] b);
    if (w == 32) begin
      bus32.valid_i = v; bus32.ctrl_i = ctrl; bus32.src1_i = a[31:0]; bus32.src2_i = b[31:0];
    end else begin
      bus8.valid_i = v; bus8.ctrl_i = ctrl; bus8.src1_i = a[7:0]; bus8.src2_i = b[7:0];
    end
  endtask

  task automatic sampleOut(input int w, output logic vld, output logic rdy, output logic [63:0] res,
                           output logic [63:0] hi, output logic z, output logic o);
    if (w == 32) begin
      vld = bus32.valid_o; rdy = bus32.ready_o; res = {32'd0, bus32.result_o};
      hi = {32'd0, bus32.hi_o}; z = bus32.zero_o; o = bus32.overflow_o;
    end else begin
      vld = bus8.valid_o; rdy = bus8.ready_o; res = {56'd0, bus8.result_o};
      hi = {56'd0, bus8.hi_o}; z = bus8.zero_o; o = bus8.overflow_o;
    end
  endtask

  // One request: wait for its pulse, check latency, busy time and results
  task automatic applyStimulus(input int w, input logic [3:0] ctrl, input logic [63:0] a,
                               input logic [63:0] b, input bit holdBusy, input string tag);
    logic [63:0] expRes, expHi, res, hi;
    logic expOvf, vld, rdy, z, o;
    bit iter, got;
    int n, lowCnt;
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    refModel(w, ctrl, a & mask, b & mask, expRes, expHi, expOvf);
    iter = (ctrl == 4'b1000) || (ctrl == 4'b1001);
    @(negedge clk);
    sampleOut(w, vld, rdy, res, hi, z, o);
    checkOutput({tag, ".readyBefore"}, {63'd0, rdy}, 64'd1);
    driveReq(w, 1'b1, ctrl, a, b);
    @(posedge clk);
    n = 0; lowCnt = 0; got = 0;
    while (n < 200 && !got) begin
      @(negedge clk);
      n++;
      sampleOut(w, vld, rdy, res, hi, z, o);
      if (!rdy) lowCnt++;
      if (vld) got = 1;
      else driveReq(w, holdBusy && !rdy, 4'b0010, 64'($urandom), 64'($urandom));
    end
    driveReq(w, 1'b0, 4'b0000, 64'd0, 64'd0);
    checkOutput({tag, ".seen"}, {63'd0, got}, 64'd1);
    checkOutput({tag, ".latency"}, 64'(n), iter ? 64'(w + 1) : 64'd1);
    checkOutput({tag, ".busy"}, 64'(lowCnt), iter ? 64'(w) : 64'd0);
    checkOutput({tag, ".result"}, res, expRes);
    checkOutput({tag, ".hi"}, hi, expHi);
    checkOutput({tag, ".zero"}, {63'd0, z}, {63'd0, expRes == 64'd0});
    checkOutput({tag, ".ovf"}, {63'd0, o}, {63'd0, expOvf});
    @(negedge clk);
    sampleOut(w, vld, rdy, res, hi, z, o);
    checkOutput({tag, ".pulseEnd"}, {63'd0, vld}, 64'd0);
    checkOutput({tag, ".held"}, res, expRes);
  endtask

  // Queued single-cycle ops issued on consecutive cycles on the 32-bit unit
  task automatic runBackToBack(input string tag);
    logic [63:0] expRes, expHi, res, hi;
    logic expOvf, vld, rdy, z, o;
    int n;
    n = b2bCtrl.size();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin
        refModel(32, b2bCtrl[i-1], b2bA[i-1], b2bB[i-1], expRes, expHi, expOvf);
        sampleOut(32, vld, rdy, res, hi, z, o);
        checkOutput($sformatf("%s[%0d].valid", tag, i - 1), {63'd0, vld}, 64'd1);
        checkOutput($sformatf("%s[%0d].ready", tag, i - 1), {63'd0, rdy}, 64'd1);
        checkOutput($sformatf("%s[%0d].result", tag, i - 1), res, expRes);
        checkOutput($sformatf("%s[%0d].hi", tag, i - 1), hi, expHi);
        checkOutput($sformatf("%s[%0d].zero", tag, i - 1), {63'd0, z}, {63'd0, expRes == 64'd0});
        checkOutput($sformatf("%s[%0d].ovf", tag, i - 1), {63'd0, o}, {63'd0, expOvf});
      end
      if (i < n) driveReq(32, 1'b1, b2bCtrl[i], b2bA[i], b2bB[i]);
      else       driveReq(32, 1'b0, 4'b0000, 64'd0, 64'd0);
    end
    b2bCtrl.delete(); b2bA.delete(); b2bB.delete();
  endtask

  function automatic logic [63:0] randOperand(input int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return mask;
      2:       return 64'($urandom_range(0, 15));
      3:       return 64'd1 << (w - 1);
      default: return 64'($urandom) & mask;
    endcase
  endfunction

  function automatic logic [3:0] randCtrl(input bit singleOnly);
    logic [3:0] codes[12];
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1111,
              4'b1100, 4'b0011, 4'b0101, 4'b1101, 4'b1000, 4'b1001};
    return codes[singleOnly ? $urandom_range(0, 9) : $urandom_range(0, 11)];
  endfunction

  // Stimulus sequence
  initial begin
    logic [63:0] res, hi;
    logic vld, rdy, z, o;
    int pulses;
    checks = 0; failures = 0;
    clk = 1'b0; rst = 1'b1;
    driveReq(32, 1'b0, 4'b0000, 64'd0, 64'd0);
    driveReq(8, 1'b0, 4'b0000, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sampleOut(k == 0 ? 32 : 8, vld, rdy, res, hi, z, o);
      checkOutput($sformatf("idle%0d.ready", k), {63'd0, rdy}, 64'd1);
      checkOutput($sformatf("idle%0d.valid", k), {63'd0, vld}, 64'd0);
      checkOutput($sformatf("idle%0d.result", k), res, 64'd0);
      checkOutput($sformatf("idle%0d.hi", k), hi, 64'd0);
      checkOutput($sformatf("idle%0d.zero", k), {63'd0, z}, 64'd1);
      checkOutput($sformatf("idle%0d.ovf", k), {63'd0, o}, 64'd0);
    end

    applyStimulus(32, 4'b0010, 64'h7FFF_FFFF, 64'h1, 0, "addOvf");

    b2bCtrl = '{4'b0110, 4'b0111, 4'b1111};
    b2bA    = '{64'd5, 64'hFFFF_FFFF, 64'hFFFF_FFFF};
    b2bB    = '{64'd5, 64'd1, 64'd1};
    runBackToBack("b2bDirected");

    applyStimulus(32, 4'b1000, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 1, "muluMax");
    applyStimulus(32, 4'b1001, 64'd100, 64'd7, 1, "divu100by7");
    applyStimulus(32, 4'b1001, 64'h1234_5678, 64'd0, 0, "divuByZero");

    applyStimulus(32, 4'b0010, 64'd3, 64'd4, 0, "preReset");
    @(negedge clk);
    driveReq(32, 1'b1, 4'b1000, 64'($urandom), 64'($urandom));
    @(posedge clk);
    @(negedge clk);
    driveReq(32, 1'b0, 4'b0000, 64'd0, 64'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    sampleOut(32, vld, rdy, res, hi, z, o);
    checkOutput("midRst.ready", {63'd0, rdy}, 64'd1);
    checkOutput("midRst.valid", {63'd0, vld}, 64'd0);
    checkOutput("midRst.result", res, 64'd0);
    checkOutput("midRst.hi", hi, 64'd0);
    checkOutput("midRst.zero", {63'd0, z}, 64'd1);
    checkOutput("midRst.ovf", {63'd0, o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      sampleOut(32, vld, rdy, res, hi, z, o);
      if (vld) pulses++;
    end
    checkOutput("midRst.noPulse", 64'(pulses), 64'd0);
    applyStimulus(32, 4'b0000, 64'hF0F0_F0F0, 64'hFF00_FF00, 0, "andAfterRst");

    applyStimulus(8, 4'b1000, 64'hFF, 64'h02, 1, "w8Mulu");
    applyStimulus(8, 4'b0010, 64'h7F, 64'h01, 0, "w8AddOvf");

    for (int i = 0; i < 20; i++) begin
      b2bCtrl.push_back(randCtrl(1));
      b2bA.push_back(randOperand(32));
      b2bB.push_back(randOperand(32));
    end
    runBackToBack("b2bRand");

    for (int i = 0; i < 40; i++)
      applyStimulus(32, randCtrl(0), randOperand(32), randOperand(32), bit'($urandom_range(0, 1)),
                    $sformatf("rand32_%0d", i));
    for (int i = 0; i < 40; i++)
      applyStimulus(8, randCtrl(0), randOperand(8), randOperand(8), bit'($urandom_range(0, 1)),
                    $sformatf("rand8_%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
